// File: rtl/flop_pkg.sv
// Shared types and defaults for the flop stage and its input conditioning logic.
package flop_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } cond_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  function automatic logic is_check(input cond_state_t s);
    return (s == CHECK_HI) || (s == CHECK_LO);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level; all stages reset to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_r;

  // shift the raw level through the synchroniser stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
    end
  end

  assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces a raw level, producing a registered level,
// one-cycle edge pulses and a busy flag while a change is being qualified.
module input_conditioner
  import flop_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din_async,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_out_s;
  cond_state_t      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             dout_r, dout_s;
  logic             rise_r, rise_s;
  logic             fall_r, fall_s;
  logic             busy_r, busy_s;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din_async),
    .dout    (sync_out_s)
  );

  // next-state, counter and output decode for the debounce FSM
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    dout_s  = dout_r;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    case (state_r)
      STABLE_LO: begin
        if (sync_out_s) begin
          state_s = CHECK_HI;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      CHECK_HI: begin
        if (!sync_out_s) begin
          state_s = STABLE_LO;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = STABLE_HI;
          dout_s  = 1'b1;
          rise_s  = 1'b1;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync_out_s) begin
          state_s = CHECK_LO;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      CHECK_LO: begin
        if (sync_out_s) begin
          state_s = STABLE_HI;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = STABLE_LO;
          dout_s  = 1'b0;
          fall_s  = 1'b1;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = STABLE_LO;
        cnt_s   = CNT_ZERO;
        dout_s  = 1'b0;
      end
    endcase
    // busy is registered from the next state so it tracks the state register exactly
    busy_s = is_check(state_s);
  end

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= STABLE_LO;
      cnt_r   <= CNT_ZERO;
      dout_r  <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dout_r  <= dout_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      busy_r  <= busy_s;
    end
  end

  assign dout       = dout_r;
  assign rise_pulse = rise_r;
  assign fall_pulse = fall_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with default parameters (2 sync stages, 4 debounce cycles).
module tb_input_conditioner;

  logic clk;
  logic reset_n;
  logic din_async;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  int n_cmp;
  int n_err;
  int rise_cnt;
  logic prev_pulse;

  typedef struct {
    logic       din;
    logic [3:0] exp;  // {dout, rise_pulse, fall_pulse, busy} after the edge
  } vec_t;

  vec_t tbl[33];

  input_conditioner dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din_async  (din_async),
    .dout       (dout),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] exp);
    n_cmp++;
    if ({dout, rise_pulse, fall_pulse, busy} !== exp) begin
      n_err++;
      $display("FAIL %s: got {dout,rise,fall,busy}=%b want %b at %0t", name,
               {dout, rise_pulse, fall_pulse, busy}, exp, $time);
    end
  endtask

  // drive din, advance one edge, then check pulse exclusivity and spacing
  task automatic step(input logic d);
    din_async = d;
    @(posedge clk);
    #1;
    if (rise_pulse) rise_cnt++;
    n_cmp++;
    if ((rise_pulse && fall_pulse) || ((rise_pulse || fall_pulse) && prev_pulse)) begin
      n_err++;
      $display("FAIL pulse_excl: got rise=%b fall=%b prev=%b want exclusive non-consecutive pulses",
               rise_pulse, fall_pulse, prev_pulse);
    end
    prev_pulse = rise_pulse | fall_pulse;
  endtask

  // hold din at d for n edges and expect a full qualification ending at edge 6
  task automatic qual(input string name, input logic d, input logic old, input int n);
    logic [3:0] exp;
    for (int k = 1; k <= n; k++) begin
      step(d);
      if (k < 3)       exp = {old, 1'b0, 1'b0, 1'b0};
      else if (k < 6)  exp = {old, 1'b0, 1'b0, 1'b1};
      else if (k == 6) exp = {d, d, ~d, 1'b0};
      else             exp = {d, 1'b0, 1'b0, 1'b0};
      check(name, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rise_cnt = 0;
    prev_pulse = 1'b0;

    // clean step up and down
    tbl[0]  = '{1'b1, 4'b0000}; tbl[1]  = '{1'b1, 4'b0000}; tbl[2]  = '{1'b1, 4'b0001};
    tbl[3]  = '{1'b1, 4'b0001}; tbl[4]  = '{1'b1, 4'b0001}; tbl[5]  = '{1'b1, 4'b1100};
    tbl[6]  = '{1'b1, 4'b1000}; tbl[7]  = '{1'b1, 4'b1000};
    tbl[8]  = '{1'b0, 4'b1000}; tbl[9]  = '{1'b0, 4'b1000}; tbl[10] = '{1'b0, 4'b1001};
    tbl[11] = '{1'b0, 4'b1001}; tbl[12] = '{1'b0, 4'b1001}; tbl[13] = '{1'b0, 4'b0010};
    tbl[14] = '{1'b0, 4'b0000}; tbl[15] = '{1'b0, 4'b0000};
    // single-cycle glitch
    tbl[16] = '{1'b1, 4'b0000}; tbl[17] = '{1'b0, 4'b0000}; tbl[18] = '{1'b0, 4'b0001};
    tbl[19] = '{1'b0, 4'b0000}; tbl[20] = '{1'b0, 4'b0000}; tbl[21] = '{1'b0, 4'b0000};
    // exactly DEBOUNCE_CYCLES wide: qualifies, then falls straight back
    tbl[22] = '{1'b1, 4'b0000}; tbl[23] = '{1'b1, 4'b0000}; tbl[24] = '{1'b1, 4'b0001};
    tbl[25] = '{1'b1, 4'b0001}; tbl[26] = '{1'b0, 4'b0001}; tbl[27] = '{1'b0, 4'b1100};
    tbl[28] = '{1'b0, 4'b1001}; tbl[29] = '{1'b0, 4'b1001}; tbl[30] = '{1'b0, 4'b1001};
    tbl[31] = '{1'b0, 4'b0010}; tbl[32] = '{1'b0, 4'b0000};

    // reset held with input high
    reset_n   = 1'b0;
    din_async = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 4'b0000);
    reset_n = 1'b1;
    qual("reset_release_rise", 1'b1, 1'b0, 8);
    qual("settle_low", 1'b0, 1'b1, 8);

    for (int i = 0; i < 33; i++) begin
      step(tbl[i].din);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // glitches of 1, 2 and 3 cycles
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < w; i++) begin
        step(1'b1);
        check($sformatf("glitch%0d_hi", w), {1'b0, 1'b0, 1'b0, busy});
      end
      for (int i = 0; i < 8; i++) begin
        step(1'b0);
        check($sformatf("glitch%0d_lo", w), {1'b0, 1'b0, 1'b0, busy});
      end
      check($sformatf("glitch%0d_idle", w), 4'b0000);
    end

    // bounce train, then hold high; back-to-back fall right after the rise
    rise_cnt = 0;
    for (int s = 0; s < 10; s++) begin
      for (int i = 0; i < 2; i++) begin
        step((s % 2) == 0);
        check("bounce", {1'b0, 1'b0, 1'b0, busy});
      end
    end
    qual("bounce_final", 1'b1, 1'b0, 6);
    n_cmp++;
    if (rise_cnt != 1) begin
      n_err++;
      $display("FAIL bounce_rise_count: got %0d want 1", rise_cnt);
    end
    qual("back_to_back_fall", 1'b0, 1'b1, 8);

    // reset during CHECK_HI with cnt=2
    for (int i = 0; i < 4; i++) step(1'b1);
    check("midchk_busy", 4'b0001);
    #2 reset_n = 1'b0;
    #1 check("midchk_async_reset", 4'b0000);
    @(posedge clk);
    #1 check("midchk_reset_hold", 4'b0000);
    reset_n = 1'b1;
    qual("midchk_requal", 1'b1, 1'b0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
